regfile_scoreboard: RTL and testbench

- Next-generation integer register file for the ysyx_22040127 core.
- Provides a parametrised number of combinational read ports, one write-back port, and an asynchronous reset that clears all registers.
- Forwards same-cycle write data to the read ports and hardwires x0 to zero.
- Embeds a per-register busy scoreboard (set at issue, cleared at write-back, bulk-cleared on flush) so decode can detect RAW/WAW hazards without external tracking.

---
 rtl/regfile_scoreboard_if.sv | 30 +++
 rtl/regfile_scoreboard.sv | 90 +++++++++
 tb/tb_regfile_scoreboard.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Bundles the write-back, read, issue and flush signals of the register file.
// Write-back, issue and flush are single-cycle strobes sampled on the rising clk edge;
// no ready exists, so the register file takes every asserted strobe in the same cycle.
interface regfile_scoreboard_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NREAD      = 2
);
    logic                        wen;
    logic [ADDR_WIDTH-1:0]       waddr;
    logic [DATA_WIDTH-1:0]       wdata;
    logic [NREAD*ADDR_WIDTH-1:0] raddr;
    logic [NREAD*DATA_WIDTH-1:0] rdata;
    logic [NREAD-1:0]            rbusy;
    logic                        iss_valid;
    logic [ADDR_WIDTH-1:0]       iss_rd;
    logic                        iss_busy;
    logic                        flush;
    logic [ADDR_WIDTH:0]         pending_cnt;

    modport master (
        output wen, waddr, wdata, raddr, iss_valid, iss_rd, flush,
        input  rdata, rbusy, iss_busy, pending_cnt
    );

    modport slave (
        input  wen, waddr, wdata, raddr, iss_valid, iss_rd, flush,
        output rdata, rbusy, iss_busy, pending_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-back bypass, hardwired x0 and a per-register
// busy scoreboard (set at issue, cleared at write-back, bulk-cleared on flush).
module regfile_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NREAD      = 2
) (
    input  logic clk,
    input  logic rst,
    regfile_scoreboard_if.slave bus
);
    localparam int NREG = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf_q [NREG];
    logic [DATA_WIDTH-1:0] rf_d [NREG];
    logic [NREG-1:0]       busy_q;
    logic [NREG-1:0]       busy_d;

    logic [NREAD*DATA_WIDTH-1:0] rdata_c;
    logic [NREAD-1:0]            rbusy_c;
    logic [ADDR_WIDTH:0]         pending_c;
    logic                        iss_busy_c;

    always_comb begin
        rf_d = rf_q;
        if (bus.wen && bus.waddr != '0) begin
            rf_d[bus.waddr] = bus.wdata;
        end
    end

    // Flush beats issue, and issue beats write-back: a fresh producer supersedes the old one.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (bus.flush) begin
                busy_d[r] = 1'b0;
            end else if (bus.iss_valid && bus.iss_rd == ADDR_WIDTH'(r)) begin
                busy_d[r] = 1'b1;
            end else if (bus.wen && bus.waddr == ADDR_WIDTH'(r)) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                rf_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        logic [ADDR_WIDTH-1:0] a;
        rdata_c = '0;
        rbusy_c = '0;
        for (int i = 0; i < NREAD; i++) begin
            a = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (a == '0) begin
                rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                rbusy_c[i]                          = 1'b0;
            end else if (bus.wen && bus.waddr == a) begin
                rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = bus.wdata;
                rbusy_c[i]                          = 1'b0;
            end else begin
                rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = rf_q[a];
                rbusy_c[i]                          = busy_q[a];
            end
        end
    end

    always_comb begin
        pending_c = '0;
        for (int r = 0; r < NREG; r++) begin
            pending_c = pending_c + {{ADDR_WIDTH{1'b0}}, busy_q[r]};
        end
    end

    assign iss_busy_c = (bus.iss_rd != '0) && busy_q[bus.iss_rd];

    assign bus.rdata       = rdata_c;
    assign bus.rbusy       = rbusy_c;
    assign bus.pending_cnt = pending_c;
    assign bus.iss_busy    = iss_busy_c;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector table plus hand-written reset sequences for regfile_scoreboard.
module tb_regfile_scoreboard;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 2;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  regfile_scoreboard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR)) bus ();

  regfile_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic          flush;
    logic [DW-1:0] e_rd0;
    logic [DW-1:0] e_rd1;
    logic [1:0]    e_rbusy;
    logic          e_iss_busy;
    logic [AW:0]   e_pc;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.wen       = 1'b0;
    bus.waddr     = '0;
    bus.wdata     = '0;
    bus.raddr     = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    bus.wen       = v.wen;
    bus.waddr     = v.waddr;
    bus.wdata     = v.wdata;
    bus.raddr     = {v.ra1, v.ra0};
    bus.iss_valid = v.iss_valid;
    bus.iss_rd    = v.iss_rd;
    bus.flush     = v.flush;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    check({tag, ".rdata0"}, bus.rdata[DW-1:0], v.e_rd0);
    check({tag, ".rdata1"}, bus.rdata[2*DW-1:DW], v.e_rd1);
    check({tag, ".rbusy"}, {62'd0, bus.rbusy}, {62'd0, v.e_rbusy});
    check({tag, ".iss_busy"}, {63'd0, bus.iss_busy}, {63'd0, v.e_iss_busy});
    check({tag, ".pending_cnt"}, {58'd0, bus.pending_cnt}, {58'd0, v.e_pc});
  endtask

  // wen waddr wdata ra0 ra1 iss_valid iss_rd flush | rd0 rd1 rbusy iss_busy pc
  task automatic fill_table();
    localparam logic [DW-1:0] ONES = {DW{1'b1}};
    vq.push_back('{1'b0, 5'd0, 64'h0,    5'd0, 5'd5, 1'b0, 5'd0, 1'b0, 64'h0,    64'h0,    2'b00, 1'b0, 6'd0});
    vq.push_back('{1'b1, 5'd5, 64'hDEAD, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 64'hDEAD, 64'h0,    2'b00, 1'b0, 6'd0});
    vq.push_back('{1'b0, 5'd0, 64'h0,    5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 64'hDEAD, 64'hDEAD, 2'b00, 1'b0, 6'd0});
    vq.push_back('{1'b1, 5'd0, ONES,     5'd0, 5'd5, 1'b0, 5'd0, 1'b0, 64'h0,    64'hDEAD, 2'b00, 1'b0, 6'd0});
    vq.push_back('{1'b0, 5'd0, 64'h0,    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 64'h0,    64'h0,    2'b00, 1'b0, 6'd0});
    vq.push_back('{1'b1, 5'd7, 64'h1234, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 64'h1234, 64'h1234, 2'b00, 1'b0, 6'd0});
    vq.push_back('{1'b0, 5'd0, 64'h0,    5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 64'h1234, 64'h1234, 2'b00, 1'b0, 6'd0});
    vq.push_back('{1'b0, 5'd0, 64'h0,    5'd3, 5'd7, 1'b1, 5'd3, 1'b0, 64'h0,    64'h1234, 2'b00, 1'b0, 6'd0});
    vq.push_back('{1'b0, 5'd0, 64'h0,    5'd3, 5'd3, 1'b0, 5'd3, 1'b0, 64'h0,    64'h0,    2'b11, 1'b1, 6'd1});
    vq.push_back('{1'b1, 5'd3, 64'hAB,   5'd3, 5'd7, 1'b0, 5'd3, 1'b0, 64'hAB,   64'h1234, 2'b00, 1'b1, 6'd1});
    vq.push_back('{1'b0, 5'd0, 64'h0,    5'd3, 5'd0, 1'b0, 5'd3, 1'b0, 64'hAB,   64'h0,    2'b00, 1'b0, 6'd0});
    vq.push_back('{1'b0, 5'd0, 64'h0,    5'd4, 5'd0, 1'b1, 5'd4, 1'b0, 64'h0,    64'h0,    2'b00, 1'b0, 6'd0});
    vq.push_back('{1'b1, 5'd4, 64'h55,   5'd4, 5'd4, 1'b1, 5'd4, 1'b0, 64'h55,   64'h55,   2'b00, 1'b1, 6'd1});
    vq.push_back('{1'b0, 5'd0, 64'h0,    5'd4, 5'd4, 1'b0, 5'd4, 1'b0, 64'h55,   64'h55,   2'b11, 1'b1, 6'd1});
    vq.push_back('{1'b1, 5'd4, 64'h66,   5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 64'h66,   64'h0,    2'b00, 1'b0, 6'd1});
    vq.push_back('{1'b0, 5'd0, 64'h0,    5'd4, 5'd1, 1'b1, 5'd1, 1'b0, 64'h66,   64'h0,    2'b00, 1'b0, 6'd0});
    vq.push_back('{1'b0, 5'd0, 64'h0,    5'd1, 5'd2, 1'b1, 5'd2, 1'b0, 64'h0,    64'h0,    2'b01, 1'b0, 6'd1});
    vq.push_back('{1'b0, 5'd0, 64'h0,    5'd2, 5'd9, 1'b1, 5'd9, 1'b0, 64'h0,    64'h0,    2'b01, 1'b0, 6'd2});
    vq.push_back('{1'b0, 5'd0, 64'h0,    5'd9, 5'd6, 1'b1, 5'd6, 1'b1, 64'h0,    64'h0,    2'b01, 1'b0, 6'd3});
    vq.push_back('{1'b0, 5'd0, 64'h0,    5'd1, 5'd6, 1'b0, 5'd6, 1'b0, 64'h0,    64'h0,    2'b00, 1'b0, 6'd0});
    vq.push_back('{1'b0, 5'd0, 64'h0,    5'd9, 5'd2, 1'b0, 5'd9, 1'b0, 64'h0,    64'h0,    2'b00, 1'b0, 6'd0});
    vq.push_back('{1'b0, 5'd0, 64'h0,    5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 64'h0,    64'h0,    2'b00, 1'b0, 6'd0});
    vq.push_back('{1'b0, 5'd0, 64'h0,    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 64'h0,    64'h0,    2'b00, 1'b0, 6'd0});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive_idle();
    rst = 1'b1;
    #2;
    check("reset.rdata0", bus.rdata[DW-1:0], 64'h0);
    check("reset.pending_cnt", {58'd0, bus.pending_cnt}, 64'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    fill_table();
    @(posedge clk);
    #1;
    for (int i = 0; i < vq.size(); i++) begin
      drive_vec(vq[i]);
      #2;
      check_vec(i, vq[i]);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-cycle: x5 holds 0xDEAD and x12 is busy.
    drive_idle();
    bus.wen       = 1'b1;
    bus.waddr     = 5'd5;
    bus.wdata     = 64'hDEAD;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd12;
    @(posedge clk);
    #1;
    drive_idle();
    bus.raddr  = {5'd12, 5'd5};
    bus.iss_rd = 5'd12;
    #1;
    check("pre_rst.rdata0", bus.rdata[DW-1:0], 64'hDEAD);
    check("pre_rst.pending_cnt", {58'd0, bus.pending_cnt}, 64'd1);
    check("pre_rst.rbusy", {62'd0, bus.rbusy}, 64'b10);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst.rdata0", bus.rdata[DW-1:0], 64'h0);
    check("async_rst.pending_cnt", {58'd0, bus.pending_cnt}, 64'd0);
    check("async_rst.rbusy", {62'd0, bus.rbusy}, 64'd0);
    check("async_rst.iss_busy", {63'd0, bus.iss_busy}, 64'd0);
    #1;
    rst = 1'b0;

    // First write after reset release lands on the very next edge.
    bus.wen   = 1'b1;
    bus.waddr = 5'd8;
    bus.wdata = 64'h77;
    @(posedge clk);
    #1;
    drive_idle();
    bus.raddr = {5'd5, 5'd8};
    #1;
    check("post_rst.x8", bus.rdata[DW-1:0], 64'h77);
    check("post_rst.x5", bus.rdata[2*DW-1:DW], 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
